// File: rtl/toggle_cover_collector_pkg.sv
// Shared constants, FSM state type and sizing helper for the toggle cover collector.
package toggle_cover_collector_pkg;

  localparam int DUMP_WORD_W = 32;
  localparam int DUMP_ADDR_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  function automatic int nwords(input int total);
    return (total + DUMP_WORD_W - 1) / DUMP_WORD_W;
  endfunction

endpackage

// File: rtl/cover_popcount.sv
// Counts the set bits of a LANES-wide vector in one combinational pass.
module cover_popcount #(
  parameter int LANES = 9,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Multi-lane toggle coverage bitmap with distinct-hit counter, sticky range error
// and a valid/ready word-serial dump of the bitmap.
module toggle_cover_collector
  import toggle_cover_collector_pkg::*;
#(
  parameter int COVER_TOTAL = 256,
  parameter int LANES       = 9,
  parameter int IDX_W       = $clog2(COVER_TOTAL)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LANES-1:0]       hit_valid,
  input  logic [IDX_W-1:0]       hit_base,
  input  logic                   clear,
  input  logic                   dump_start,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [DUMP_ADDR_W-1:0] dump_addr,
  output logic [DUMP_WORD_W-1:0] dump_data,
  output logic                   dump_last,
  output logic                   busy,
  output logic [IDX_W:0]         covered_count,
  output logic                   err_range
);

  localparam int NWORDS    = nwords(COVER_TOTAL);
  localparam int WSEL_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int NWORDS_P2 = 1 << WSEL_W;
  localparam int PAD_W     = NWORDS_P2 * DUMP_WORD_W;
  localparam int POP_W     = $clog2(LANES + 1);

  logic [COVER_TOTAL-1:0] bitmap_reg;
  logic [IDX_W:0]         count_reg;
  logic                   err_reg;

  logic [LANES-1:0]       commit;
  logic [LANES-1:0]       fresh;
  logic [LANES-1:0]       oob;
  logic [IDX_W:0]         lane_idx [LANES];
  logic [COVER_TOTAL-1:0] set_mask;
  logic [POP_W-1:0]       new_count;

  // Lane index is formed one bit wider than the cover index so base+i never wraps.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic in_range;
      assign lane_idx[gi] = {1'b0, hit_base} + (IDX_W+1)'(gi);
      assign in_range     = lane_idx[gi] < (IDX_W+1)'(COVER_TOTAL);
      assign commit[gi]   = enable & ~clear & hit_valid[gi] & in_range;
      assign oob[gi]      = enable & ~clear & hit_valid[gi] & ~in_range;
      assign fresh[gi]    = commit[gi] & ~bitmap_reg[lane_idx[gi][IDX_W-1:0]];
    end
  endgenerate

  always_comb begin
    set_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (commit[i]) begin
        set_mask[lane_idx[i][IDX_W-1:0]] = 1'b1;
      end
    end
  end

  cover_popcount #(
    .LANES (LANES),
    .CNT_W (POP_W)
  ) u_popcount (
    .bits  (fresh),
    .count (new_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitmap_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (clear) begin
      bitmap_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      bitmap_reg <= bitmap_reg | set_mask;
      count_reg  <= count_reg + (IDX_W+1)'(new_count);
      if (|oob) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Bitmap viewed as dump words; padding beyond COVER_TOTAL reads as zero.
  logic [PAD_W-1:0]       bitmap_pad;
  logic [DUMP_WORD_W-1:0] words [NWORDS_P2];

  assign bitmap_pad = PAD_W'(bitmap_reg);

  generate
    for (genvar gi = 0; gi < NWORDS_P2; gi++) begin : g_word
      assign words[gi] = bitmap_pad[gi*DUMP_WORD_W +: DUMP_WORD_W];
    end
  endgenerate

  state_t                 state_reg, state_next;
  logic [DUMP_ADDR_W-1:0] addr_reg, addr_next, addr_inc;
  logic [DUMP_WORD_W-1:0] data_reg, data_next;
  logic                   last_reg, last_next;

  assign addr_inc = addr_reg + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (dump_start && !clear) begin
          state_next = DUMP;
          addr_next  = '0;
          data_next  = words[0];
          last_next  = (NWORDS == 1);
        end
      end
      DUMP: begin
        if (clear) begin
          state_next = IDLE;
        end else if (dump_ready) begin
          if (last_reg) begin
            state_next = IDLE;
          end else begin
            // Loads from the registered bitmap, so same-cycle hits are not included.
            addr_next = addr_inc;
            data_next = words[addr_inc[WSEL_W-1:0]];
            last_next = (addr_inc == DUMP_ADDR_W'(NWORDS - 1));
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dump_valid    = (state_reg == DUMP);
  assign busy          = (state_reg == DUMP);
  assign dump_addr     = addr_reg;
  assign dump_data     = data_reg;
  assign dump_last     = last_reg;
  assign covered_count = count_reg;
  assign err_range     = err_reg;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed and randomized checks of the toggle cover collector against a set-of-points model.
module tb_toggle_cover_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [8:0]  hit_valid;
  logic [7:0]  hit_base;
  logic        clear;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [15:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        busy;
  logic [8:0]  covered_count;
  logic        err_range;

  toggle_cover_collector dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .hit_valid     (hit_valid),
    .hit_base      (hit_base),
    .clear         (clear),
    .dump_start    (dump_start),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_addr     (dump_addr),
    .dump_data     (dump_data),
    .dump_last     (dump_last),
    .busy          (busy),
    .covered_count (covered_count),
    .err_range     (err_range)
  );

  always #5 clock = ~clock;

  bit model [256];
  bit m_err;
  int checks = 0;
  int errors = 0;

  function automatic int model_count();
    int n = 0;
    for (int p = 0; p < 256; p++) n += model[p] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [31:0] model_word(input int w);
    logic [31:0] r = '0;
    for (int j = 0; j < 32; j++) r[j] = model[32*w + j];
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 256; p++) model[p] = 1'b0;
    m_err = 1'b0;
  endtask

  // Applies the current inputs to the model, then advances one clock.
  task automatic cycle();
    if (clear) begin
      model_reset();
    end else if (enable) begin
      for (int i = 0; i < 9; i++) begin
        if (hit_valid[i]) begin
          if (int'(hit_base) + i < 256) model[int'(hit_base) + i] = 1'b1;
          else m_err = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 64'(covered_count), 64'(model_count()));
    chk({tag, "_err"}, 64'(err_range), 64'(m_err));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_addr"}, 64'(dump_addr), 64'd0);
    chk({tag, "_data"}, 64'(dump_data), 64'd0);
    chk({tag, "_last"}, 64'(dump_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_count"}, 64'(covered_count), 64'd0);
    chk({tag, "_err"}, 64'(err_range), 64'd0);
  endtask

  task automatic full_dump(input string tag);
    dump_start = 1'b1;
    dump_ready = 1'b1;
    cycle();
    dump_start = 1'b0;
    for (int w = 0; w < 8; w++) begin
      chk($sformatf("%s_valid%0d", tag, w), 64'(dump_valid), 64'd1);
      chk($sformatf("%s_addr%0d", tag, w), 64'(dump_addr), 64'(w));
      chk($sformatf("%s_data%0d", tag, w), 64'(dump_data), 64'(model_word(w)));
      chk($sformatf("%s_last%0d", tag, w), 64'(dump_last), 64'(w == 7));
      cycle();
    end
    chk({tag, "_end_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_end_busy"}, 64'(busy), 64'd0);
  endtask

  logic [31:0] held;

  initial begin
    reset = 1'b1; enable = 1'b0; hit_valid = '0; hit_base = '0;
    clear = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_zero_outputs("reset");

    // All nine lanes from base 0, then the identical hit again.
    enable = 1'b1; hit_base = 8'd0; hit_valid = 9'h1FF;
    cycle();
    hit_valid = '0;
    chk("first9_count", 64'(covered_count), 64'd9);
    hit_valid = 9'h1FF;
    cycle();
    hit_valid = '0;
    chk("repeat9_count", 64'(covered_count), 64'd9);

    // Lanes straddling the top of the range.
    hit_base = 8'd250; hit_valid = 9'h1FF;
    cycle();
    hit_valid = '0;
    chk("top_count", 64'(covered_count), 64'd15);
    chk("top_err", 64'(err_range), 64'd1);
    chk_state("top_model");

    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clear_count", 64'(covered_count), 64'd0);
    chk("clear_err", 64'(err_range), 64'd0);

    // Points 0, 33, 255 then a full dump.
    hit_base = 8'd0;   hit_valid = 9'h001; cycle();
    hit_base = 8'd33;  cycle();
    hit_base = 8'd255; cycle();
    hit_valid = '0;
    chk("three_count", 64'(covered_count), 64'd3);
    full_dump("dump3");

    // Stall at word 2 while point 64 is hit.
    dump_start = 1'b1; dump_ready = 1'b1;
    cycle();
    dump_start = 1'b0;
    cycle();
    cycle();
    chk("stall_addr_pre", 64'(dump_addr), 64'd2);
    dump_ready = 1'b0;
    held = model_word(2);
    hit_base = 8'd64; hit_valid = 9'h001;
    for (int k = 0; k < 5; k++) begin
      cycle();
      hit_valid = '0;
      chk($sformatf("stall_data%0d", k), 64'(dump_data), 64'(held));
      chk($sformatf("stall_addr%0d", k), 64'(dump_addr), 64'd2);
      chk($sformatf("stall_valid%0d", k), 64'(dump_valid), 64'd1);
    end
    dump_ready = 1'b1;
    for (int w = 2; w < 8; w++) begin
      chk($sformatf("resume_addr%0d", w), 64'(dump_addr), 64'(w));
      chk($sformatf("resume_last%0d", w), 64'(dump_last), 64'(w == 7));
      if (w > 2) chk($sformatf("resume_data%0d", w), 64'(dump_data), 64'(model_word(w)));
      cycle();
    end
    chk("resume_end_valid", 64'(dump_valid), 64'd0);
    full_dump("after64");

    // Clear at word 3 together with a hit on point 5.
    dump_start = 1'b1; dump_ready = 1'b1;
    cycle();
    dump_start = 1'b0;
    repeat (3) cycle();
    chk("abort_addr_pre", 64'(dump_addr), 64'd3);
    clear = 1'b1; hit_base = 8'd5; hit_valid = 9'h001;
    cycle();
    clear = 1'b0; hit_valid = '0;
    chk("abort_valid", 64'(dump_valid), 64'd0);
    chk("abort_count", 64'(covered_count), 64'd0);
    chk("abort_err", 64'(err_range), 64'd0);
    full_dump("zeroed");

    // Random hit traffic with occasional clears.
    for (int n = 0; n < 200; n++) begin
      enable    = ($urandom_range(0, 3) != 0);
      hit_base  = 8'($urandom_range(0, 255));
      hit_valid = 9'($urandom);
      clear     = ($urandom_range(0, 31) == 0);
      cycle();
      chk_state($sformatf("rand%0d", n));
    end
    enable = 1'b0; clear = 1'b0; hit_valid = '0;
    full_dump("rand_dump");

    // Asynchronous reset in the middle of a dump.
    enable = 1'b1;
    dump_start = 1'b1; dump_ready = 1'b1;
    cycle();
    dump_start = 1'b0;
    repeat (4) cycle();
    chk("mid_addr_pre", 64'(dump_addr), 64'd4);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_zero_outputs("async_reset");
    @(negedge clock);
    reset = 1'b0;
    hit_base = 8'd7; hit_valid = 9'h003;
    cycle();
    hit_valid = '0;
    chk_state("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_cover_collector.md
TOGGLE_COVER_COLLECTOR -- requirements
Module: toggle_cover_collector

Interface
REQ-001 Parameter COVER_TOTAL, default 256: number of toggle cover points tracked (valid range 1..65536).
REQ-002 Parameter LANES, default 9: hit lanes accepted per cycle.
REQ-003 Parameter IDX_W, default $clog2(COVER_TOTAL): cover-index width.
REQ-004 Port clock, input, 1: sole clock, rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port enable, input, 1: when low, hits are ignored.
REQ-007 Port hit_valid, input, LANES: lane i reports a hit on cover point hit_base+i.
REQ-008 Port hit_base, input, IDX_W: base cover index for the lanes.
REQ-009 Port clear, input, 1: synchronous wipe of all coverage state.
REQ-010 Port dump_start, input, 1: request a full bitmap dump.
REQ-011 Port dump_valid, output, 1: a dump word is presented.
REQ-012 Port dump_ready, input, 1: the consumer accepts the word.
REQ-013 Port dump_addr, output, 16: word index of dump_data.
REQ-014 Port dump_data, output, 32: bitmap word; bit j is cover point 32*dump_addr+j.
REQ-015 Port dump_last, output, 1: the presented word is the final word.
REQ-016 Port busy, output, 1: high while in state DUMP.
REQ-017 Port covered_count, output, IDX_W+1: number of distinct points hit.
REQ-018 Port err_range, output, 1: sticky flag, set when a hit indexes at or beyond COVER_TOTAL.

Function
REQ-019 A lane hit is committed when all of these hold: enable=1, clear=0, hit_valid[i]=1, and hit_base+i < COVER_TOTAL; the sum is computed at IDX_W+1 bits with no wrap.
REQ-020 A committed hit sets bitmap bit hit_base+i at the next edge; the bitmap and covered_count reflect the hit one cycle later.
REQ-021 covered_count increases by the number of committed lanes whose bit was previously 0; repeat hits on an already-set bit add nothing.
REQ-022 An out-of-range hit (valid lane with enable=1 and clear=0) sets err_range and leaves the bitmap and count unchanged.
REQ-023 clear=1 zeroes the bitmap, covered_count and err_range at the next edge; clear takes priority over same-cycle hits and over dump activity.
REQ-024 FSM states: IDLE and DUMP.
  - IDLE->DUMP: on dump_start=1 with clear=0; dump_addr is set to 0 and the output register loads word 0.
  - dump_start is ignored while in DUMP.
REQ-025 In DUMP, dump_valid=1. dump_addr, dump_data and dump_last stay stable while dump_ready=0.
REQ-026 A transfer occurs when dump_valid=1 and dump_ready=1.
  - Non-last word: dump_addr increments and the register loads the next word from the registered bitmap, excluding hits committed in that same cycle.
REQ-027 NWORDS = ceil(COVER_TOTAL/32); dump_last=1 when dump_addr=NWORDS-1; bits at or beyond COVER_TOTAL read as 0.
REQ-028 A transfer on the last word returns the FSM to IDLE; dump_valid is 0 on the next cycle.
REQ-029 clear=1 in DUMP aborts the dump: state goes to IDLE and dump_valid drops at the next edge.
REQ-030 Hits continue to be committed during a dump; a word already loaded into the output register does not change.

Reset
REQ-031 Asserting reset asynchronously forces: state=IDLE, bitmap=0, covered_count=0, err_range=0, dump_valid=0, dump_addr=0, dump_data=0, dump_last=0, busy=0.
REQ-032 Reset deassertion is synchronized externally; the block commits no hit in the cycle reset is high.

Structure
REQ-033 A shared package holds:
  - DUMP_WORD_W=32 and DUMP_ADDR_W=16;
  - the FSM state enum (IDLE, DUMP);
  - the function nwords(total).
REQ-034 The per-cycle new-hit popcount over LANES bits is implemented as sub-module cover_popcount (input LANES bits, output $clog2(LANES+1) bits).
REQ-035 The bitmap is flop-based with no memory macro; the design is synthesizable with no DPI.

Verification
REQ-036 After reset: enable=1, hit_base=0, hit_valid=9'h1FF for one cycle -> covered_count=9 next cycle.
  - Repeating the identical hit -> count stays 9.
REQ-037 hit_base=250, hit_valid=9'h1FF, COVER_TOTAL=256 -> bits 250..255 set, count +6, err_range=1.
REQ-038 Hits on points 0, 33 and 255, then dump_start with dump_ready held 1 -> 8 words (addr 0..7).
  - word0=32'h1, word1=32'h2, word7=32'h8000_0000.
  - dump_last=1 only on addr 7; busy falls after that transfer.
REQ-039 Dump with dump_ready=0 for 5 cycles at addr 2 while hitting point 64 -> dump_data stays unchanged.
  - Next dump shows word2 bit0=1.
REQ-040 clear asserted at addr 3 of a dump together with a hit on point 5 -> next cycle: dump_valid=0, covered_count=0, bitmap all zero.
REQ-041 Reset asserted mid-dump at addr 4 -> all outputs 0 immediately, without waiting for a clock edge.
